// File: rtl/alu_pkg.sv
// Shared encodings for the ALU sequencer: FSM states, opcodes and ALU selector constants.
package alu_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_LOAD = 2'b01,
    S_EXEC = 2'b10,
    S_RESP = 2'b11
  } state_e;

  localparam logic [2:0] OP_AND     = 3'd0;
  localparam logic [2:0] OP_OR      = 3'd1;
  localparam logic [2:0] OP_NOT     = 3'd2;
  localparam logic [2:0] OP_XOR     = 3'd3;
  localparam logic [2:0] OP_ADD     = 3'd4;
  localparam logic [2:0] OP_SUB     = 3'd5;
  localparam logic [2:0] OP_MULT    = 3'd6;
  localparam logic [2:0] OP_ILLEGAL = 3'd7;

  localparam logic [2:0] IN_SEL_RESET   = 3'b001;
  localparam logic [2:0] IN_SEL_LOAD    = 3'b010;
  localparam logic [2:0] IN_SEL_PERSIST = 3'b100;

  localparam logic [6:0] OUT_SEL_NONE = 7'b000_0000;

  function automatic logic [6:0] op_onehot(input logic [2:0] op);
    logic [6:0] sel;
    sel = OUT_SEL_NONE;
    if (op != OP_ILLEGAL) sel = 7'b000_0001 << op;
    return sel;
  endfunction

  // Only SUB and MULT report a meaningful overflow from the ALU.
  function automatic logic op_has_err(input logic [2:0] op);
    return (op == OP_SUB) || (op == OP_MULT);
  endfunction

endpackage

// File: rtl/alu_sequencer_if.sv
// Requester command and response bus of the ALU sequencer.
interface alu_sequencer_if #(parameter int WIDTH = 8);
  logic             req0_valid;
  logic             req1_valid;
  logic [2:0]       req0_op;
  logic [2:0]       req1_op;
  logic [WIDTH-1:0] req0_a;
  logic [WIDTH-1:0] req0_b;
  logic [WIDTH-1:0] req1_a;
  logic [WIDTH-1:0] req1_b;
  logic             req0_ready;
  logic             req1_ready;
  logic             rsp_valid;
  logic             rsp_id;
  logic [WIDTH-1:0] rsp_data;
  logic             rsp_err;

  modport master (
    output req0_valid, req1_valid, req0_op, req1_op,
    output req0_a, req0_b, req1_a, req1_b,
    input  req0_ready, req1_ready,
    input  rsp_valid, rsp_id, rsp_data, rsp_err
  );

  modport slave (
    input  req0_valid, req1_valid, req0_op, req1_op,
    input  req0_a, req0_b, req1_a, req1_b,
    output req0_ready, req1_ready,
    output rsp_valid, rsp_id, rsp_data, rsp_err
  );
endinterface

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter; the pointer remembers the last winner and moves only on update.
module rr_arb2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       update,
  output logic [1:0] gnt
);

  logic last_q, last_d;

  always_comb begin
    gnt = 2'b00;
    case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = last_q ? 2'b01 : 2'b10;
      default: gnt = 2'b00;
    endcase
    last_d = last_q;
    if (update) last_d = gnt[1];
  end

  // Reset as if req1 just won, so req0 is favoured first.
  always_ff @(posedge clk) begin
    if (rst) last_q <= 1'b1;
    else     last_q <= last_d;
  end

endmodule

// File: rtl/alu_sequencer.sv
// Arbitrates two requesters and steps an external ALU through load/execute, then returns one response.
//   state  | meaning
//   S_IDLE | waiting for a command, ready granted combinationally
//   S_LOAD | operands presented to the ALU with the load selector
//   S_EXEC | opcode one-hot driven, ALU result captured at cycle end
//   S_RESP | one-cycle response strobe
module alu_sequencer
  import alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  alu_sequencer_if.slave   bus,
  output logic [2:0]       alu_in_selector,
  output logic [WIDTH-1:0] alu_num1,
  output logic [WIDTH-1:0] alu_num2,
  output logic [6:0]       alu_out_selector,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_err,
  output logic             busy
);

  state_e           state_q, state_d;
  logic [2:0]       op_q, op_d;
  logic             id_q, id_d;
  logic [WIDTH-1:0] num1_q, num1_d;
  logic [WIDTH-1:0] num2_q, num2_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             err_q, err_d;
  logic [1:0]       req_vld;
  logic [1:0]       gnt;
  logic             hs;

  assign req_vld = {bus.req1_valid, bus.req0_valid} & {2{(state_q == S_IDLE) && !rst}};
  assign hs      = |gnt;

  rr_arb2 u_arb (
    .clk    (clk),
    .rst    (rst),
    .req    (req_vld),
    .update (hs),
    .gnt    (gnt)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      op_q    <= '0;
      id_q    <= 1'b0;
      num1_q  <= '0;
      num2_q  <= '0;
      res_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      id_q    <= id_d;
      num1_q  <= num1_d;
      num2_q  <= num2_d;
      res_q   <= res_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    id_d    = id_q;
    num1_d  = num1_q;
    num2_d  = num2_q;
    res_d   = res_q;
    err_d   = err_q;
    case (state_q)
      S_IDLE: begin
        if (hs) begin
          id_d = gnt[1];
          op_d = gnt[1] ? bus.req1_op : bus.req0_op;
          // Illegal ops skip the ALU entirely, so the operand registers keep their old values.
          if (op_d == OP_ILLEGAL) begin
            state_d = S_RESP;
          end else begin
            state_d = S_LOAD;
            num1_d  = gnt[1] ? bus.req1_a : bus.req0_a;
            num2_d  = gnt[1] ? bus.req1_b : bus.req0_b;
          end
        end
      end
      S_LOAD: state_d = S_EXEC;
      S_EXEC: begin
        res_d   = alu_result;
        err_d   = alu_err;
        state_d = S_RESP;
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    bus.req0_ready   = gnt[0];
    bus.req1_ready   = gnt[1];
    bus.rsp_valid    = 1'b0;
    bus.rsp_id       = 1'b0;
    bus.rsp_data     = '0;
    bus.rsp_err      = 1'b0;
    alu_in_selector  = IN_SEL_PERSIST;
    alu_out_selector = OUT_SEL_NONE;
    alu_num1         = num1_q;
    alu_num2         = num2_q;
    busy             = (state_q != S_IDLE);
    case (state_q)
      S_LOAD: alu_in_selector = IN_SEL_LOAD;
      S_EXEC: alu_out_selector = op_onehot(op_q);
      S_RESP: begin
        bus.rsp_valid = 1'b1;
        bus.rsp_id    = id_q;
        if (op_q == OP_ILLEGAL) begin
          bus.rsp_err = 1'b1;
        end else begin
          bus.rsp_data = res_q;
          bus.rsp_err  = op_has_err(op_q) & err_q;
        end
      end
      default: ;
    endcase
    if (rst) begin
      bus.rsp_valid    = 1'b0;
      bus.rsp_id       = 1'b0;
      bus.rsp_data     = '0;
      bus.rsp_err      = 1'b0;
      alu_in_selector  = IN_SEL_RESET;
      alu_out_selector = OUT_SEL_NONE;
      alu_num1         = '0;
      alu_num2         = '0;
      busy             = 1'b0;
    end
  end

endmodule

// File: tb/tb_alu_sequencer.sv
// Self-checking bench for alu_sequencer: behavioural ALU, transaction-level reference model, directed and random traffic.
module tb_alu_sequencer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [2:0] alu_in_selector;
  logic [7:0] alu_num1, alu_num2;
  logic [6:0] alu_out_selector;
  logic [7:0] alu_result;
  logic       alu_err;
  logic       busy;

  always #5 clk = ~clk;

  alu_sequencer_if #(.WIDTH(8)) bus ();

  alu_sequencer #(.WIDTH(8)) dut (
    .clk              (clk),
    .rst              (rst),
    .bus              (bus),
    .alu_in_selector  (alu_in_selector),
    .alu_num1         (alu_num1),
    .alu_num2         (alu_num2),
    .alu_out_selector (alu_out_selector),
    .alu_result       (alu_result),
    .alu_err          (alu_err),
    .busy             (busy)
  );

  // Behavioural ALU: flags carry/borrow/overflow for ADD, SUB and MULT.
  always_comb begin
    logic [15:0] s;
    s = 16'd0;
    alu_err = 1'b0;
    case (alu_out_selector)
      7'b0000001: s = {8'd0, alu_num1 & alu_num2};
      7'b0000010: s = {8'd0, alu_num1 | alu_num2};
      7'b0000100: s = {8'd0, ~alu_num1};
      7'b0001000: s = {8'd0, alu_num1 ^ alu_num2};
      7'b0010000: begin s = alu_num1 + alu_num2; alu_err = (s[15:8] != 8'd0); end
      7'b0100000: begin s = alu_num1 - alu_num2; alu_err = (alu_num1 < alu_num2); end
      7'b1000000: begin s = alu_num1 * alu_num2; alu_err = (s[15:8] != 8'd0); end
      default:    s = 16'd0;
    endcase
    alu_result = s[7:0];
  end

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
  endtask

  // Expected {err, data} of a command, from the opcode table.
  function automatic logic [8:0] ref_rsp(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
    int ia, ib, r;
    logic e;
    ia = a; ib = b; e = 1'b0;
    case (op)
      3'd0: r = ia & ib;
      3'd1: r = ia | ib;
      3'd2: r = 255 - ia;
      3'd3: r = ia ^ ib;
      3'd4: r = ia + ib;
      3'd5: begin r = ia - ib; e = (ia < ib); end
      3'd6: begin r = ia * ib; e = (r > 255); end
      default: begin r = 0; e = 1'b1; end
    endcase
    return {e, r[7:0]};
  endfunction

  // Transaction-level model state
  logic       pend = 1'b0;
  int         age = 0;
  logic [2:0] p_op;
  logic [7:0] p_a, p_b;
  logic       p_id;
  logic       last_gnt = 1'b1;
  logic [7:0] last_a = 8'd0, last_b = 8'd0;
  logic       gnt_log[$];
  int         hs_cnt = 0, rsp_cnt = 0;

  always @(negedge clk) begin : monitor
    logic [1:0] v, exp_rdy;
    logic       g, exp_rv, exp_busy;
    logic [2:0] exp_in;
    logic [6:0] exp_out;
    logic [8:0] r;
    if (rst) begin
      check_eq("rst_ready", {bus.req1_ready, bus.req0_ready}, 2'b00);
      check_eq("rst_rsp_valid", bus.rsp_valid, 1'b0);
      check_eq("rst_rsp_data", bus.rsp_data, 8'd0);
      check_eq("rst_in_sel", alu_in_selector, 3'b001);
      check_eq("rst_out_sel", alu_out_selector, 7'd0);
      check_eq("rst_nums", {alu_num1, alu_num2}, 16'd0);
      check_eq("rst_busy", busy, 1'b0);
      pend = 1'b0; last_gnt = 1'b1; last_a = 8'd0; last_b = 8'd0;
    end else begin
      exp_busy = pend;
      exp_rdy  = 2'b00;
      exp_rv   = 1'b0;
      exp_in   = 3'b100;
      exp_out  = 7'd0;
      if (pend) begin
        age++;
        if (p_op != 3'd7 && age == 1) begin exp_in = 3'b010; last_a = p_a; last_b = p_b; end
        if (p_op != 3'd7 && age == 2) exp_out = 7'b0000001 << p_op;
        if (age == ((p_op == 3'd7) ? 1 : 3)) begin
          exp_rv = 1'b1;
          r = ref_rsp(p_op, p_a, p_b);
          check_eq("rsp_id", bus.rsp_id, p_id);
          check_eq("rsp_data", bus.rsp_data, r[7:0]);
          check_eq("rsp_err", bus.rsp_err, r[8]);
          pend = 1'b0;
          rsp_cnt++;
        end
      end else begin
        v = {bus.req1_valid, bus.req0_valid};
        if (v != 2'b00) begin
          g = (v == 2'b11) ? !last_gnt : v[1];
          exp_rdy  = g ? 2'b10 : 2'b01;
          last_gnt = g;
          gnt_log.push_back(g);
          pend = 1'b1; age = 0; p_id = g;
          p_op = g ? bus.req1_op : bus.req0_op;
          p_a  = g ? bus.req1_a  : bus.req0_a;
          p_b  = g ? bus.req1_b  : bus.req0_b;
          hs_cnt++;
        end
      end
      check_eq("ready", {bus.req1_ready, bus.req0_ready}, exp_rdy);
      check_eq("rsp_valid", bus.rsp_valid, exp_rv);
      check_eq("in_sel", alu_in_selector, exp_in);
      check_eq("out_sel", alu_out_selector, exp_out);
      check_eq("num1", alu_num1, last_a);
      check_eq("num2", alu_num2, last_b);
      check_eq("busy", busy, exp_busy);
    end
  end

  task automatic rand_req(input int id);
    if (id == 0) begin
      bus.req0_valid = 1'b1; bus.req0_op = 3'($urandom_range(0, 7));
      bus.req0_a = 8'($urandom); bus.req0_b = 8'($urandom);
    end else begin
      bus.req1_valid = 1'b1; bus.req1_op = 3'($urandom_range(0, 7));
      bus.req1_a = 8'($urandom); bus.req1_b = 8'($urandom);
    end
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic send_one(input int id, input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                          output int lat, output logic [7:0] d, output logic e, output logic rid,
                          output logic [6:0] xsel, output logic ld);
    int n;
    @(posedge clk); #1;
    if (id == 0) begin bus.req0_valid = 1'b1; bus.req0_op = op; bus.req0_a = a; bus.req0_b = b; end
    else         begin bus.req1_valid = 1'b1; bus.req1_op = op; bus.req1_a = a; bus.req1_b = b; end
    n = 0;
    @(negedge clk);
    while (((id == 0) ? bus.req0_ready : bus.req1_ready) !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check_eq("hs_wait", n < 20, 1'b1);
    @(posedge clk); #1;
    bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
    lat = 0; d = 8'd0; e = 1'b0; rid = 1'b0; xsel = 7'd0; ld = 1'b0;
    while (lat < 10) begin
      @(negedge clk);
      lat++;
      if (alu_in_selector == 3'b010) ld = 1'b1;
      if (lat == 2) xsel = alu_out_selector;
      if (bus.rsp_valid) begin
        d = bus.rsp_data; e = bus.rsp_err; rid = bus.rsp_id;
        break;
      end
    end
  endtask

  initial begin
    int         lat, n, h0, r0c, rv_seen;
    logic [7:0] d;
    logic       e, rid, ld, r0, r1, g;
    logic [6:0] xsel;
    bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
    bus.req0_op = 3'd0; bus.req1_op = 3'd0;
    bus.req0_a = 8'd0; bus.req0_b = 8'd0; bus.req1_a = 8'd0; bus.req1_b = 8'd0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    send_one(0, 3'd4, 8'd20, 8'd22, lat, d, e, rid, xsel, ld);
    check_eq("add_lat", lat, 3);
    check_eq("add_data", d, 8'd42);
    check_eq("add_err", e, 1'b0);
    check_eq("add_id", rid, 1'b0);
    check_eq("add_exec_sel", xsel, 7'b0010000);
    check_eq("add_load", ld, 1'b1);

    send_one(1, 3'd6, 8'd16, 8'd32, lat, d, e, rid, xsel, ld);
    check_eq("mult_lat", lat, 3);
    check_eq("mult_err", e, 1'b1);
    check_eq("mult_id", rid, 1'b1);
    check_eq("mult_exec_sel", xsel, 7'b1000000);

    send_one(0, 3'd7, 8'd5, 8'd6, lat, d, e, rid, xsel, ld);
    check_eq("ill_lat", lat, 1);
    check_eq("ill_err", e, 1'b1);
    check_eq("ill_data", d, 8'd0);
    check_eq("ill_no_load", ld, 1'b0);

    // Both requesters held valid from reset: grants alternate starting with req0.
    do_reset();
    gnt_log.delete();
    rand_req(0);
    rand_req(1);
    n = 0;
    while (gnt_log.size() < 4 && n < 60) begin
      @(negedge clk);
      r0 = bus.req0_ready; r1 = bus.req1_ready;
      @(posedge clk); #1;
      if (r0) rand_req(0);
      if (r1) rand_req(1);
      n++;
    end
    bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
    check_eq("rr_count", gnt_log.size() >= 4, 1'b1);
    for (int i = 0; i < 4; i++) begin
      g = (i < gnt_log.size()) ? gnt_log[i] : 1'bx;
      check_eq($sformatf("rr_gnt%0d", i), g, i % 2);
    end
    repeat (6) @(posedge clk);

    // Reset during EXEC aborts the command silently.
    #1;
    bus.req0_valid = 1'b1; bus.req0_op = 3'd4; bus.req0_a = 8'd100; bus.req0_b = 8'd100;
    @(negedge clk);
    check_eq("abort_hs", bus.req0_ready, 1'b1);
    @(posedge clk); #1;
    bus.req0_valid = 1'b0;
    @(posedge clk); #1;
    check_eq("abort_in_exec", alu_out_selector, 7'b0010000);
    rst = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    check_eq("abort_in_sel", alu_in_selector, 3'b001);
    check_eq("abort_busy", busy, 1'b0);
    @(posedge clk); #1;
    rst = 1'b0;
    rv_seen = 0;
    repeat (6) begin
      @(negedge clk);
      if (bus.rsp_valid) rv_seen++;
    end
    check_eq("abort_no_rsp", rv_seen, 0);

    // Random traffic, including requesters that give up before being served.
    h0 = hs_cnt; r0c = rsp_cnt;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      r0 = bus.req0_ready; r1 = bus.req1_ready;
      @(posedge clk); #1;
      if (r0) begin
        if ($urandom_range(0, 1) == 1) rand_req(0); else bus.req0_valid = 1'b0;
      end else if (bus.req0_valid) begin
        if ($urandom_range(0, 7) == 0) bus.req0_valid = 1'b0;
      end else if ($urandom_range(0, 2) == 0) rand_req(0);
      if (r1) begin
        if ($urandom_range(0, 1) == 1) rand_req(1); else bus.req1_valid = 1'b0;
      end else if (bus.req1_valid) begin
        if ($urandom_range(0, 7) == 0) bus.req1_valid = 1'b0;
      end else if ($urandom_range(0, 2) == 0) rand_req(1);
    end
    bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
    repeat (8) @(posedge clk);
    check_eq("rand_activity", (hs_cnt - h0) > 100, 1'b1);
    check_eq("rand_all_rsp", rsp_cnt - r0c, hs_cnt - h0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
